mac_tx_buf: RTL and testbench
=============================

MAC_TX_BUF -- requirements
Module: mac_tx_buf

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4, meaning byte lanes per entry.
REQ-002 SHALL have parameter W_BYTE, default 8, meaning bits per lane.
REQ-003 SHALL have parameter DEPTH, default 8, meaning entries stored; power of two, at least 2.
REQ-004 SHALL have parameter IDLE_SYM, default 8'h07, meaning the lane value output when empty.
REQ-005 SHALL have port i_clk, input, 1, clock.
REQ-006 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_clk_en, input, 1, clock enable qualifying every non-reset update.
REQ-008 SHALL have port i_clear, input, 1, flush request.
REQ-009 SHALL have port i_wen, input, 1, write request.
REQ-010 SHALL have port i_wctrl, input, N_CHANNELS, per-lane control flag (1 = control symbol).
REQ-011 SHALL have port i_wdata, input, N_CHANNELS x W_BYTE, lane data with lane 0 in the LSBs.
REQ-012 SHALL have port i_ren, input, 1, read/pop request.
REQ-013 SHALL have port o_rctrl, output, N_CHANNELS, head-entry control flags.
REQ-014 SHALL have port o_rdata, output, N_CHANNELS x W_BYTE, head-entry data.
REQ-015 SHALL have port o_empty, output, 1, no entries stored.
REQ-016 SHALL have port o_full, output, 1, DEPTH entries stored.
REQ-017 SHALL have port o_level, output, clog2(DEPTH)+1, entry count.
REQ-018 SHALL have port o_ovf, output, 1, sticky write-while-full drop flag.
REQ-019 SHALL have port o_udf, output, 1, sticky read-while-empty flag.

Function
REQ-020 SHALL store each entry as {wctrl, wdata} in a circular array with write and read pointers of clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
REQ-021 SHALL wrap pointer index bits modulo DEPTH; o_level SHALL equal wptr-rptr modulo 2^(clog2(DEPTH)+1).
REQ-022 SHALL derive o_empty when wptr==rptr, and o_full when the index bits are equal and the MSBs differ; both are combinational from registered pointers.
REQ-023 SHALL be first-word-fall-through: when not empty, o_rdata/o_rctrl SHALL show the head entry with no read latency.
REQ-024 SHALL drive o_rdata to IDLE_SYM on every lane and o_rctrl to all ones when empty.
REQ-025 SHALL accept a write when i_clk_en & i_wen & (!o_full | read accepted in the same cycle); the entry is visible at the head one cycle later at earliest.
REQ-026 SHALL accept a read when i_clk_en & i_ren & !o_empty, advancing rptr by 1.
REQ-027 SHALL accept both operations on simultaneous read and write when full; the level is unchanged.
REQ-028 SHALL, on simultaneous read and write when empty, reject the read (no bypass), set o_udf, and accept the write (level becomes 1).
REQ-029 SHALL, on a write rejected while full (no read that cycle), drop the data, leave pointers unchanged, and set o_ovf.
REQ-030 SHALL, on i_clk_en & i_clear, zero both pointers and clear o_ovf/o_udf; i_clear overrides i_wen/i_ren in the same cycle.
REQ-031 SHALL hold all state and ignore i_wen, i_ren and i_clear when i_clk_en=0.
REQ-032 SHALL keep o_ovf/o_udf set until i_clear or i_reset.

Reset
REQ-033 SHALL, while i_reset=1 (independent of i_clk_en), zero both pointers, clear o_ovf/o_udf, and leave storage contents undefined.
REQ-034 SHALL drive these outputs after reset: o_empty=1, o_full=0, o_level=0, o_rdata=IDLE_SYM on all lanes, o_rctrl=all ones, o_ovf=0, o_udf=0.
REQ-035 SHALL let reset mid-operation discard all stored entries, with no partial entry surviving.

Verification
REQ-036 Reset, then write 32'h04030201/ctrl 0 -> next cycle o_empty=0, o_level=1, o_rdata=32'h04030201, o_rctrl=0; pop -> o_empty=1, o_rdata=32'h07070707, o_rctrl=4'hF.
REQ-037 Write 8 entries 0..7 without reading -> o_full=1, o_level=8; 9th write -> o_ovf=1, level 8; read order returns 0..7.
REQ-038 Fill to full, then write and read in the same cycle -> level stays 8, head advances, o_ovf=0.
REQ-039 Empty FIFO, i_ren=1 and i_wen=1 together -> o_udf=1, o_level=1, head = written data.
REQ-040 Write 3 entries with i_clk_en toggling 1/0 -> only the enabled cycles count (level 2 for pattern 1,0,1); then i_clear with i_wen=1 -> level 0, flags 0.
REQ-041 Wrap-around: 20 interleaved write/read pairs at level 3 -> data order preserved across pointer wrap; reset mid-stream -> o_empty=1 next cycle.

Source files
------------

// File: rtl/mac_tx_buf.sv
// MAC transmit buffer: first-word-fall-through FIFO of per-lane data/control entries.
// Shows idle symbols on every lane while empty; sticky overflow/underflow flags.
module mac_tx_buf #(
  parameter int N_CHANNELS = 4,
  parameter int W_BYTE = 8,
  parameter int DEPTH = 8,
  parameter logic [W_BYTE-1:0] IDLE_SYM = 8'h07
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clk_en,
  input  logic i_clear,
  input  logic i_wen,
  input  logic [N_CHANNELS-1:0] i_wctrl,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_wdata,
  input  logic i_ren,
  output logic [N_CHANNELS-1:0] o_rctrl,
  output logic [N_CHANNELS*W_BYTE-1:0] o_rdata,
  output logic o_empty,
  output logic o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic o_ovf,
  output logic o_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = N_CHANNELS * W_BYTE;
  localparam int EW = DW + N_CHANNELS;
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic empty, full, rd_acc, wr_acc, op_en;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
        && (wptr_q[AW] != rptr_q[AW]);
    op_en = i_clk_en & ~i_clear;
    // A pop frees a slot, so a write while full is fine in the same cycle.
    rd_acc = op_en & i_ren & ~empty;
    wr_acc = op_en & i_wen & (~full | rd_acc);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (i_clk_en & i_clear) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (rd_acc) rptr_d = rptr_q + ONE;
      if (wr_acc) wptr_d = wptr_q + ONE;
      if (op_en & i_ren & empty) udf_d = 1'b1;
      if (op_en & i_wen & ~wr_acc) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && wr_acc) begin
      mem_q[wptr_q[AW-1:0]] <= {i_wctrl, i_wdata};
    end
  end

  always_comb begin
    head = mem_q[rptr_q[AW-1:0]];
    o_empty = empty;
    o_full = full;
    o_level = wptr_q - rptr_q;
    o_ovf = ovf_q;
    o_udf = udf_q;
    if (empty) begin
      o_rdata = {N_CHANNELS{IDLE_SYM}};
      o_rctrl = '1;
    end else begin
      o_rdata = head[DW-1:0];
      o_rctrl = head[EW-1:DW];
    end
  end

endmodule

// File: tb/tb_mac_tx_buf.sv
// Bench for mac_tx_buf: directed steps against a queue-based reference model.
// Expected head entries live in a scoreboard queue pushed on accepted writes.
module tb_mac_tx_buf;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_clk_en = 1'b0;
  logic i_clear = 1'b0;
  logic i_wen = 1'b0;
  logic [3:0] i_wctrl = '0;
  logic [31:0] i_wdata = '0;
  logic i_ren = 1'b0;
  logic [3:0] o_rctrl;
  logic [31:0] o_rdata;
  logic o_empty, o_full, o_ovf, o_udf;
  logic [3:0] o_level;

  logic [35:0] sb[$];
  bit m_ovf, m_udf;
  int total = 0;
  int bad = 0;

  mac_tx_buf dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
    .i_clear(i_clear), .i_wen(i_wen), .i_wctrl(i_wctrl),
    .i_wdata(i_wdata), .i_ren(i_ren), .o_rctrl(o_rctrl),
    .o_rdata(o_rdata), .o_empty(o_empty), .o_full(o_full),
    .o_level(o_level), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n;
    n = sb.size();
    chk({tag, ".empty"}, 64'(o_empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(o_full), 64'(n == 8));
    chk({tag, ".level"}, 64'(o_level), 64'(n));
    chk({tag, ".ovf"}, 64'(o_ovf), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(o_udf), 64'(m_udf));
    if (n == 0)
      chk({tag, ".idle"}, 64'({o_rctrl, o_rdata}), 64'h0_F_07070707);
    else
      chk({tag, ".head"}, 64'({o_rctrl, o_rdata}), 64'(sb[0]));
  endtask

  task automatic op(bit en, bit wen, bit ren, bit clr,
                    logic [31:0] d, logic [3:0] c);
    bit rd, wr;
    i_clk_en = en;
    i_wen = wen;
    i_ren = ren;
    i_clear = clr;
    i_wdata = d;
    i_wctrl = c;
    if (en) begin
      if (clr) begin
        sb.delete();
        m_ovf = 0;
        m_udf = 0;
      end else begin
        rd = ren && sb.size() > 0;
        wr = wen && (sb.size() < 8 || rd);
        if (ren && sb.size() == 0) m_udf = 1;
        if (wen && !wr) m_ovf = 1;
        if (rd) void'(sb.pop_front());
        if (wr) sb.push_back({c, d});
      end
    end
    @(posedge i_clk);
    #1;
    i_clk_en = 1'b1;
    i_wen = 1'b0;
    i_ren = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_clk_en = 1'b0;
    i_wen = 1'b1;
    i_wdata = 32'hDEADBEEF;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_wen = 1'b0;
    i_clk_en = 1'b1;
    sb.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  initial begin
    do_reset();
    check_all("reset");

    op(1, 1, 0, 0, 32'h04030201, 4'h0);
    check_all("wr1");
    chk("wr1.data", 64'(o_rdata), 64'h04030201);
    op(1, 0, 1, 0, '0, '0);
    check_all("pop1");
    chk("pop1.rctrl", 64'(o_rctrl), 64'hF);

    for (int i = 0; i < 8; i++) begin
      op(1, 1, 0, 0, 32'(i), 4'(i));
      check_all("fill");
    end
    chk("fill.full", 64'(o_full), 64'h1);
    op(1, 1, 0, 0, 32'h99, 4'h0);
    check_all("ovf");
    chk("ovf.flag", 64'(o_ovf), 64'h1);
    for (int i = 0; i < 8; i++) begin
      chk("order", 64'(o_rdata), 64'(i));
      op(1, 0, 1, 0, '0, '0);
      check_all("drain");
    end

    op(0, 0, 1, 1, '0, '0);
    check_all("gated");
    op(1, 0, 0, 1, '0, '0);
    check_all("clr1");

    for (int i = 0; i < 8; i++) op(1, 1, 0, 0, 32'h100 + 32'(i), 4'h5);
    check_all("full2");
    op(1, 1, 1, 0, 32'h1AA, 4'hA);
    check_all("rw_full");
    chk("rw_full.level", 64'(o_level), 64'h8);
    chk("rw_full.head", 64'(o_rdata), 64'h101);

    op(1, 0, 0, 1, '0, '0);
    op(1, 1, 1, 0, 32'h55, 4'h3);
    check_all("rw_empty");
    chk("rw_empty.udf", 64'(o_udf), 64'h1);
    chk("rw_empty.data", 64'(o_rdata), 64'h55);

    op(1, 0, 0, 1, '0, '0);
    op(1, 1, 0, 0, 32'hA1, 4'h1);
    op(0, 1, 0, 0, 32'hA2, 4'h2);
    op(1, 1, 0, 0, 32'hA3, 4'h3);
    check_all("clken");
    chk("clken.level", 64'(o_level), 64'h2);
    op(1, 1, 0, 1, 32'hA4, 4'h4);
    check_all("clr_wen");
    chk("clr_wen.level", 64'(o_level), 64'h0);

    for (int i = 0; i < 3; i++) op(1, 1, 0, 0, 32'h200 + 32'(i), 4'(i));
    for (int i = 0; i < 20; i++) begin
      op(1, 1, 1, 0, 32'h300 + 32'(i), 4'(i + 3));
      check_all("wrap");
    end
    do_reset();
    check_all("midrst");
    chk("midrst.empty", 64'(o_empty), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
